pc_updown_ctr: RTL and testbench
================================

Name: pc_updown_ctr

Overview:
- Loadable up/down binary counter for the memory/fetch path. Used as an address/program counter for instruction memory.
- Counts up or down by one per enabled clock.
- Loads an arbitrary value on a jump request.
- Provides wrap-around status for the surrounding control logic.

Parameters:
- WIDTH, 10, counter and jump-location width in bits.
- RST_VAL, 0, value loaded by reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  count enable; 1 = step this edge, 0 = hold.
- dir  input  1  count direction; 1 = up (+1), 0 = down (-1).
- jmp  input  1  synchronous load request.
- jmpLoc  input  WIDTH  value loaded when jmp=1.
- ctrOut  output  WIDTH  registered counter value.
- wrap  output  1  registered one-cycle pulse; 1 when the last update wrapped (up from max, or down from 0).

Behaviour:
- Reset
  - rst=0 immediately forces ctrOut=RST_VAL and wrap=0, independent of clk.
  - Deassertion is synchronous to the design; the first update occurs on the first rising edge with rst=1.
- Priority on each rising edge with rst=1: jmp > en > hold.
- jmp=1: ctrOut <= jmpLoc. Applies even when en=0. wrap <= 0. dir is ignored.
- jmp=0, en=1, dir=1: ctrOut <= ctrOut+1 modulo 2^WIDTH. If ctrOut was 2^WIDTH-1, the result is 0 and wrap <= 1.
- jmp=0, en=1, dir=0: ctrOut <= ctrOut-1 modulo 2^WIDTH. If ctrOut was 0, the result is 2^WIDTH-1 and wrap <= 1.
- jmp=0, en=0: ctrOut holds; wrap <= 0.
- wrap is high for exactly the one cycle following a wrapping step; otherwise 0.
- Latency: one clock from input sampling to ctrOut change. There is no combinational path from inputs to outputs.
- dir change: takes effect on the next enabled edge; no dead cycle.
- Jump to an extreme value: jmp with jmpLoc = 2^WIDTH-1, followed by an up step, wraps to 0 with wrap=1.
- Reset mid-count: asserting rst at any time, including between edges, forces RST_VAL at once. Counting resumes from RST_VAL after deassertion.
- No X propagation: all registers are reset.

Decomposition:
- Shared package ctr_pkg:
  - CTR_WIDTH_DEFAULT = 10.
  - Direction constants DIR_UP = 1'b1 and DIR_DOWN = 1'b0.
  - Optional typedef ctr_t as a WIDTH-bit vector.
- Single flat module; no sub-module is required.
- The next-value/wrap logic is one combinational block feeding one register bank.

Test Plan:
- Reset then count up: rst=0 for 10 ns, then rst=1, en=1, dir=1, jmp=0, 20 ns clock. ctrOut must be 0 after reset, then 1, 2, … reaching 10 after 10 rising edges. wrap=0 throughout.
- Direction change: from ctrOut=10, set dir=0. ctrOut must go 9, 8, … 0 over 10 edges. The next edge gives 1023 with wrap=1 for one cycle, then 1022 with wrap=0.
- Jump: with counting in progress, pulse jmp=1 with jmpLoc=69 for one edge, dir=1. ctrOut must be 69 on that edge, then 70, 71. The jump also loads with en=0, and ctrOut holds at 69 afterwards.
- Hold: en=0 for 5 edges at ctrOut=42. ctrOut must stay 42 and wrap stay 0. Re-enable with dir=1 and the next edge gives 43.
- Up wrap via jump: jmpLoc=1023, jmp pulse, then en=1, dir=1. ctrOut must go 1023 then 0 with a wrap pulse, then 1.
- Asynchronous reset mid-count: drive rst=0 at ctrOut=500, halfway between edges. ctrOut must read 0 before the next rising edge and stay 0 while rst=0.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared constants and types for the fetch-path program counter.
package ctr_pkg;

    localparam int CTR_WIDTH_DEFAULT = 10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef logic [CTR_WIDTH_DEFAULT-1:0] ctr_t;

endpackage

// File: rtl/pc_updown_ctr.sv
// Loadable up/down program counter with a registered wrap pulse.
module pc_updown_ctr
    import ctr_pkg::*;
#(
    parameter int               WIDTH   = CTR_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmpLoc,
    output logic [WIDTH-1:0] ctrOut,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] ctr_nxt;
    logic             wrap_nxt;

    // Jump beats counting; wrap only flags a counting step across the boundary.
    always_comb begin
        ctr_nxt  = ctrOut;
        wrap_nxt = 1'b0;
        if (jmp) begin
            ctr_nxt = jmpLoc;
        end else if (en) begin
            if (dir == DIR_UP) begin
                ctr_nxt  = ctrOut + ONE;
                wrap_nxt = (ctrOut == '1);
            end else begin
                ctr_nxt  = ctrOut - ONE;
                wrap_nxt = (ctrOut == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrOut <= RST_VAL;
            wrap   <= 1'b0;
        end else begin
            ctrOut <= ctr_nxt;
            wrap   <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_pc_updown_ctr.sv
// Scoreboard bench for pc_updown_ctr at the default 10-bit width.
module tb_pc_updown_ctr;

    localparam int W   = 10;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic         en;
    logic         dir;
    logic         jmp;
    logic [W-1:0] jmpLoc;
    logic [W-1:0] ctrOut;
    logic         wrap;

    typedef struct {
        int c;
        int w;
    } exp_t;

    exp_t q[$];
    int   m;
    int   n_vec;
    int   n_bad;

    pc_updown_ctr #(.WIDTH(W), .RST_VAL('0)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .dir    (dir),
        .jmp    (jmp),
        .jmpLoc (jmpLoc),
        .ctrOut (ctrOut),
        .wrap   (wrap)
    );

    initial begin
        clk = 1'b1;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, wanted %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input string tag, input logic e, input logic d,
                        input logic j, input int loc);
        exp_t x;
        exp_t y;
        en     = e;
        dir    = d;
        jmp    = j;
        jmpLoc = W'(loc);
        x.w = 0;
        if (j) begin
            m = loc;
        end else if (e) begin
            if (d) begin
                x.w = (m == MOD - 1) ? 1 : 0;
                m   = (m + 1) % MOD;
            end else begin
                x.w = (m == 0) ? 1 : 0;
                m   = (m + MOD - 1) % MOD;
            end
        end
        x.c = m;
        q.push_back(x);
        @(posedge clk);
        #1;
        y = q.pop_front();
        check({tag, ".ctr"}, int'(ctrOut), y.c);
        check({tag, ".wrap"}, int'(wrap), y.w);
        @(negedge clk);
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        m      = 0;
        rst    = 1'b0;
        en     = 1'b0;
        dir    = 1'b1;
        jmp    = 1'b0;
        jmpLoc = '0;
        #5;
        check("rst.ctr", int'(ctrOut), 0);
        check("rst.wrap", int'(wrap), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) step("up", 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) step("down", 1'b1, 1'b0, 1'b0, 0);
        step("dwrap", 1'b1, 1'b0, 1'b0, 0);
        step("dpost", 1'b1, 1'b0, 1'b0, 0);

        step("jmp", 1'b1, 1'b1, 1'b1, 69);
        step("jup", 1'b1, 1'b1, 1'b0, 0);
        step("jup", 1'b1, 1'b1, 1'b0, 0);
        step("jnoen", 1'b0, 1'b0, 1'b1, 69);
        step("jhold", 1'b0, 1'b1, 1'b0, 0);

        step("ld42", 1'b0, 1'b0, 1'b1, 42);
        for (int i = 0; i < 5; i++) step("hold", 1'b0, 1'b0, 1'b0, 0);
        step("reen", 1'b1, 1'b1, 1'b0, 0);

        step("jmax", 1'b0, 1'b0, 1'b1, MOD - 1);
        step("uwrap", 1'b1, 1'b1, 1'b0, 0);
        step("upost", 1'b1, 1'b1, 1'b0, 0);

        step("ld499", 1'b0, 1'b1, 1'b1, 499);
        step("to500", 1'b1, 1'b1, 1'b0, 0);
        #5;
        rst = 1'b0;
        #1;
        check("arst.ctr", int'(ctrOut), 0);
        check("arst.wrap", int'(wrap), 0);
        @(posedge clk);
        #1;
        check("arst.hold", int'(ctrOut), 0);
        @(negedge clk);
        rst = 1'b1;
        m   = 0;
        step("resume", 1'b1, 1'b1, 1'b0, 0);
        step("resume", 1'b1, 1'b1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
